// File: rtl/range_argmax.sv
// Streams a window [lo_addr, hi_addr] of a synchronous-read RAM and reports the largest word and
// its address. Define RANGE_ARGMAX_ABS_EN to rank by saturated magnitude instead of signed value.
module range_argmax #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int RD_LAT     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] lo_addr,
  input  logic [ADDR_WIDTH-1:0] hi_addr,
  output logic                  busy,
  output logic                  done,
  output logic                  range_err,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0] ram_data,
  output logic [DATA_WIDTH-1:0] max_val,
  output logic [ADDR_WIDTH-1:0] max_idx
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SCAN  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] MOST_POS = {1'b0, {(DATA_WIDTH-1){1'b1}}};

`ifdef RANGE_ARGMAX_ABS_EN
  localparam logic [DATA_WIDTH-1:0] INIT_MAX = '0;
`else
  localparam logic [DATA_WIDTH-1:0] INIT_MAX = MOST_NEG;
`endif

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] hi_q;
  logic [RD_LAT-1:0]     sr_valid;
  logic [RD_LAT-1:0]     sr_valid_d;
  logic [ADDR_WIDTH-1:0] sr_addr [RD_LAT];
  logic                  issue;
  logic                  idle_or_done;
  logic [DATA_WIDTH-1:0] cand;
  logic                  update;

  assign busy         = (state == S_SCAN) || (state == S_DRAIN);
  assign done         = (state == S_DONE);
  assign issue        = (state == S_SCAN);
  assign idle_or_done = (state == S_IDLE) || (state == S_DONE);

  // Each issued address is tagged so the compare knows which address the returning word is for.
  always_comb begin
    sr_valid_d    = '0;
    sr_valid_d[0] = issue;
    for (int i = 1; i < RD_LAT; i++) begin
      sr_valid_d[i] = sr_valid[i-1];
    end
  end

`ifdef RANGE_ARGMAX_ABS_EN
  always_comb begin
    cand = ram_data;
    if (ram_data == MOST_NEG) begin
      cand = MOST_POS;
    end else if (ram_data[DATA_WIDTH-1]) begin
      cand = -ram_data;
    end
  end
`else
  assign cand = ram_data;
`endif

  // Strict compare keeps the lowest address on ties.
  assign update = sr_valid[RD_LAT-1] && ($signed(cand) > $signed(max_val));

  always_ff @(posedge clk) begin
    sr_addr[0] <= ram_addr;
    for (int i = 1; i < RD_LAT; i++) begin
      sr_addr[i] <= sr_addr[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      hi_q      <= '0;
      sr_valid  <= '0;
      range_err <= 1'b0;
      ram_addr  <= '0;
      max_val   <= MOST_NEG;
      max_idx   <= '0;
    end else begin
      range_err <= 1'b0;
      sr_valid  <= sr_valid_d;
      if (update) begin
        max_val <= cand;
        max_idx <= sr_addr[RD_LAT-1];
      end
      case (state)
        S_IDLE, S_DONE: begin
          if (start && idle_or_done) begin
            if (lo_addr <= hi_addr) begin
              hi_q     <= hi_addr;
              ram_addr <= lo_addr;
              max_val  <= INIT_MAX;
              max_idx  <= lo_addr;
              state    <= S_SCAN;
            end else begin
              range_err <= 1'b1;
            end
          end
        end
        S_SCAN: begin
          // Compare against hi rather than hi+1 so the top address never wraps.
          if (ram_addr == hi_q) begin
            state <= S_DRAIN;
          end else begin
            ram_addr <= ram_addr + ADDR_WIDTH'(1);
          end
        end
        S_DRAIN: begin
          if (sr_valid_d == '0) begin
            state <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
